ej32_mbus_arb: RTL

Multi-channel, width-converting arbiter in front of the single 8-bit SRAM port of the eJ32 system. Up to NCH requesters (core fetch, core data, DMA/console) each issue 1-, 2- or 4-byte big-endian reads or writes. The block grants one channel at a time, round-robin, serialises the access into byte cycles on the 8-bit memory bus and returns the assembled word with a one-cycle acknowledge. It replaces the direct core-to-SRAM wiring at top level.

---
 rtl/ej32_mbus_arb_if.sv | 37 +++
 rtl/ej32_mbus_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ej32_mbus_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ej32_mbus_arb_if
// Brief   : Requester-side and SRAM-side signal bundle of the eJ32 memory
//           bus arbiter. "slave" is the arbiter view, "master" the view of
//           the requesters plus the SRAM.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface ej32_mbus_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 17,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [2*NCH-1:0]  sz;
  logic [AW*NCH-1:0] addr;
  logic [DW*NCH-1:0] wdata;
  logic [DW-1:0]     rdata;
  logic [NCH-1:0]    ack;
  logic              busy;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [7:0]        mem_do;
  logic [7:0]        mem_di;

  modport slave (
    input  req, we, sz, addr, wdata, mem_di,
    output rdata, ack, busy, mem_addr, mem_we, mem_do
  );

  modport master (
    output req, we, sz, addr, wdata, mem_di,
    input  rdata, ack, busy, mem_addr, mem_we, mem_do
  );
endinterface
`default_nettype wire

// File: rtl/ej32_mbus_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ej32_mbus_arb
// Brief   : Round-robin arbiter that serialises 1/2/4-byte big-endian
//           channel accesses onto the 8-bit SRAM port and returns the
//           assembled word with a one-cycle acknowledge.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module ej32_mbus_arb #(
  parameter int NCH = 2,
  parameter int AW  = 17,
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  ej32_mbus_arb_if.slave bus
);
  localparam int         GW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] C_MAX_LAST = 2'(DW / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_last;
  logic          r_we;
  logic [1:0]    r_k;      // byte index within the access
  logic [1:0]    r_nl;     // index of the final byte (n-1)
  logic [DW-1:0] r_wsh;    // write data, next byte to send in the top lane
  logic [DW-1:0] r_acc;    // read accumulator
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_addr;

  logic          w_any;
  logic [GW-1:0] w_gnt;
  int            w_idx;
  logic          w_we;
  logic [1:0]    w_sz;
  logic [1:0]    w_nl;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Round-robin search starting at the channel after the last one served.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = 0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = (int'(r_last) + i) % NCH;
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_gnt = GW'(w_idx);
      end
    end
  end

  assign w_we    = bus.we[w_gnt];
  assign w_sz    = bus.sz[int'(w_gnt)*2 +: 2];
  assign w_addr  = bus.addr[int'(w_gnt)*AW +: AW];
  assign w_wdata = bus.wdata[int'(w_gnt)*DW +: DW];

  // Last-byte index from the size code, clamped to the channel data width.
  always_comb begin
    w_nl = 2'd3;
    case (w_sz)
      2'd0:    w_nl = 2'd0;
      2'd1:    w_nl = 2'd1;
      default: w_nl = 2'd3;
    endcase
    if (w_nl > C_MAX_LAST) begin
      w_nl = C_MAX_LAST;
    end
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the strobes that depend only on the current state.
  always_comb begin
    w_next       = r_state;
    bus.ack      = '0;
    bus.mem_we   = 1'b0;
    bus.busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        bus.mem_we = r_we;
        if (r_k == r_nl) begin
          w_next = r_we ? S_ACK : S_WAIT;
        end
      end
      S_WAIT:  w_next = S_ACK;
      S_ACK: begin
        bus.ack[r_gnt] = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the granted request, step address/data per byte, and
  // assemble read bytes which arrive one cycle after their address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= '0;
      r_last     <= GW'(NCH - 1);
      r_we       <= 1'b0;
      r_k        <= 2'd0;
      r_nl       <= 2'd0;
      r_wsh      <= '0;
      r_acc      <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_gnt;
            r_we       <= w_we;
            r_nl       <= w_nl;
            r_k        <= 2'd0;
            r_mem_addr <= w_addr;
            r_wsh      <= w_wdata << (DW - 8 * (int'(w_nl) + 1));
            r_acc      <= '0;
          end
        end
        S_ISSUE: begin
          r_k   <= r_k + 2'd1;
          r_wsh <= r_wsh << 8;
          if (r_k != r_nl) begin
            r_mem_addr <= r_mem_addr + 1'b1;
          end
          if (r_k != 2'd0) begin
            r_acc <= (r_acc << 8) | DW'(bus.mem_di);
          end
        end
        S_WAIT: begin
          r_acc   <= (r_acc << 8) | DW'(bus.mem_di);
          r_rdata <= (r_acc << 8) | DW'(bus.mem_di);
        end
        S_ACK: r_last <= r_gnt;
        default: ;
      endcase
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_do   = r_wsh[DW-1 -: 8];

endmodule
`default_nettype wire
